// File: rtl/axis_vec_pkg.sv
// Shared types and defaults for the buffered AXI4-Stream vector transmitter.
package axis_vec_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/vec_buf.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one asynchronous read port.
module vec_buf
  import axis_vec_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/axis_vec_tx.sv
// Buffered AXI4-Stream packet transmitter: words loaded into vec_buf while idle are
// emitted as one TLAST-terminated packet on start, honouring TREADY backpressure.
module axis_vec_tx
  import axis_vec_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned DEPTH      = DEPTH_DEF,
  localparam int unsigned ADDR_W     = $clog2(DEPTH),
  localparam int unsigned LEN_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [DATA_WIDTH-1:0] OUTPUT_AXIS_TDATA,
  output logic                  OUTPUT_AXIS_TLAST,
  output logic                  OUTPUT_AXIS_TVALID,
  input  logic                  OUTPUT_AXIS_TREADY
);

  tx_state_t             state, state_nxt;
  logic [ADDR_W-1:0]     idx, idx_nxt, rd_addr_c;
  logic [LEN_W-1:0]      len_q, len_nxt;
  logic [DATA_WIDTH-1:0] rd_data_c, tdata_nxt;
  logic                  tvalid_nxt, tlast_nxt, busy_nxt, done_nxt, len_err_nxt;
  logic                  len_ok_c, hs_c, last_beat_c, buf_wr_c;

  assign len_ok_c    = (len != '0) && (len <= LEN_W'(DEPTH));
  assign hs_c        = OUTPUT_AXIS_TVALID && OUTPUT_AXIS_TREADY;
  assign last_beat_c = (LEN_W'(idx) + LEN_W'(1)) == len_q;
  // Packet contents are frozen once sending starts.
  assign buf_wr_c    = wr_en && (state == IDLE);
  // Idle prefetches word 0; while sending, look ahead to the next beat.
  assign rd_addr_c   = (state == SEND) ? idx + ADDR_W'(1) : '0;

  vec_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (buf_wr_c),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr_c),
    .rd_data_c (rd_data_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      idx                <= '0;
      len_q              <= '0;
      OUTPUT_AXIS_TDATA  <= '0;
      OUTPUT_AXIS_TLAST  <= 1'b0;
      OUTPUT_AXIS_TVALID <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      len_err            <= 1'b0;
    end else begin
      state              <= state_nxt;
      idx                <= idx_nxt;
      len_q              <= len_nxt;
      OUTPUT_AXIS_TDATA  <= tdata_nxt;
      OUTPUT_AXIS_TLAST  <= tlast_nxt;
      OUTPUT_AXIS_TVALID <= tvalid_nxt;
      busy               <= busy_nxt;
      done               <= done_nxt;
      len_err            <= len_err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len_ok_c) state_nxt = SEND;
      SEND:    if (hs_c && last_beat_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt     = idx;
    len_nxt     = len_q;
    tdata_nxt   = OUTPUT_AXIS_TDATA;
    tlast_nxt   = OUTPUT_AXIS_TLAST;
    tvalid_nxt  = OUTPUT_AXIS_TVALID;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    len_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_ok_c) begin
            idx_nxt    = '0;
            len_nxt    = len;
            tdata_nxt  = rd_data_c;
            tlast_nxt  = (len == LEN_W'(1));
            tvalid_nxt = 1'b1;
            busy_nxt   = 1'b1;
          end else begin
            len_err_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (hs_c) begin
          if (last_beat_c) begin
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            tdata_nxt = rd_data_c;
            // Next beat is last when idx+1 == len-1.
            tlast_nxt = (LEN_W'(idx) + LEN_W'(2)) == len_q;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
